// File: rtl/led_frame_sequencer.sv
// Frame sequencer for one-wire addressable-LED strips: walks pixel addresses, times
// each pixel's serial shift, inserts the latch gap, then paces frames around the calc engine.
module led_frame_sequencer #(
    parameter int NUM_PIXELS          = 64,
    parameter int BITS_PER_PIXEL      = 24,
    parameter int CYCLES_PER_BIT      = 15,
    parameter int LATCH_CYCLES        = 600,
    parameter int FRAME_PERIOD_CYCLES = 12_000_000,
    localparam int PIX_W              = $clog2(NUM_PIXELS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             done_calculating_i,
    input  logic             overrun_clr_i,
    output logic             start_calculating_o,
    output logic             load_sreg_o,
    output logic             transmit_pixel_o,
    output logic             latching_o,
    output logic [PIX_W-1:0] pixel_o,
    output logic             idle_o,
    output logic             overrun_o
);
    localparam int SHIFT_CYCLES = BITS_PER_PIXEL * CYCLES_PER_BIT;
    localparam int CNT_MAX      = (SHIFT_CYCLES > LATCH_CYCLES) ? SHIFT_CYCLES : LATCH_CYCLES;
    localparam int CNT_W        = $clog2(CNT_MAX + 1);
    localparam int TMR_W        = $clog2(FRAME_PERIOD_CYCLES + 1);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NUM_PIXELS - 1);
    localparam logic [TMR_W-1:0] TMR_DUE    = TMR_W'(FRAME_PERIOD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_SAT    = TMR_W'(FRAME_PERIOD_CYCLES);

    typedef enum logic [2:0] {
        S_READ, S_LOAD, S_SHIFT, S_LATCH, S_CALC, S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             overrun_set;
    logic             load_sreg_q, transmit_q, latching_q, start_q, idle_q, overrun_q;

    // One counter serves both the per-pixel shift time and the latch gap; it is
    // always back at zero when either phase is entered.
    always_comb begin
        state_d     = state_q;
        pixel_d     = pixel_q;
        cnt_d       = cnt_q;
        overrun_set = 1'b0;
        case (state_q)
            S_READ: state_d = S_LOAD;
            S_LOAD: state_d = S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d = '0;
                    if (pixel_q == PIX_LAST) begin
                        state_d = S_LATCH;
                    end else begin
                        pixel_d = pixel_q + PIX_W'(1);
                        state_d = S_READ;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d   = '0;
                    pixel_d = '0;
                    state_d = S_CALC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CALC: begin
                if (done_calculating_i) begin
                    if (timer_q == TMR_SAT) begin
                        overrun_set = 1'b1;
                        state_d     = enable_i ? S_READ : S_WAIT;
                    end else if (timer_q == TMR_DUE && enable_i) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (enable_i && timer_q >= TMR_DUE) state_d = S_READ;
            end
            default: state_d = S_READ;
        endcase

        // Frame period is measured start-to-start: zero on entering pixel 0's READ.
        if (state_d == S_READ && (state_q == S_CALC || state_q == S_WAIT)) begin
            timer_d = '0;
        end else if (timer_q != TMR_SAT) begin
            timer_d = timer_q + TMR_W'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_READ;
            pixel_q     <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            load_sreg_q <= 1'b0;
            transmit_q  <= 1'b0;
            latching_q  <= 1'b0;
            start_q     <= 1'b0;
            idle_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pixel_q     <= pixel_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            load_sreg_q <= (state_d == S_LOAD);
            transmit_q  <= (state_d == S_SHIFT);
            latching_q  <= (state_d == S_LATCH);
            start_q     <= (state_d == S_CALC) && (state_q != S_CALC);
            idle_q      <= (state_d == S_WAIT);
            overrun_q   <= overrun_set | (overrun_q & ~overrun_clr_i);
        end
    end

    assign start_calculating_o = start_q;
    assign load_sreg_o         = load_sreg_q;
    assign transmit_pixel_o    = transmit_q;
    assign latching_o          = latching_q;
    assign pixel_o             = pixel_q;
    assign idle_o              = idle_q;
    assign overrun_o           = overrun_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench: each planned frame pushes its expected output events (cycle, kind,
// value) into a queue; a negedge monitor pops and compares them as the DUT produces them.
module tb_led_frame_sequencer;
    localparam int NP       = 4;
    localparam int BPP      = 24;
    localparam int CPB      = 15;
    localparam int LAT      = 10;
    localparam int FP       = 2000;
    localparam int P        = 2 + BPP * CPB;
    localparam int CALC_OFF = NP * P + LAT;
    localparam int PW       = $clog2(NP);

    localparam int EV_LOAD      = 0;
    localparam int EV_SHIFT_END = 1;
    localparam int EV_LATCH_BEG = 2;
    localparam int EV_LATCH_END = 3;
    localparam int EV_START     = 4;
    localparam int EV_IDLE_BEG  = 5;
    localparam int EV_IDLE_END  = 6;
    localparam int EV_OVR_SET   = 7;
    localparam int EV_OVR_CLR   = 8;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n, enable, done_calculating, overrun_clr;
    logic          start_calculating, load_sreg, transmit_pixel, latching, idle, overrun;
    logic [PW-1:0] pixel;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    ev_t exp_q[$];
    ev_t fr_q[$];
    bit  mon_on = 1'b0;
    bit  zero_exp = 1'b0;
    bit  end_req = 1'b0;
    bit  after_rst = 1'b0;
    bit  ovr_m = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_frame_sequencer #(
        .NUM_PIXELS(NP), .BITS_PER_PIXEL(BPP), .CYCLES_PER_BIT(CPB),
        .LATCH_CYCLES(LAT), .FRAME_PERIOD_CYCLES(FP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .done_calculating_i(done_calculating), .overrun_clr_i(overrun_clr),
        .start_calculating_o(start_calculating), .load_sreg_o(load_sreg),
        .transmit_pixel_o(transmit_pixel), .latching_o(latching),
        .pixel_o(pixel), .idle_o(idle), .overrun_o(overrun)
    );

    function automatic string kname(int k);
        case (k)
            EV_LOAD:      return "load_sreg";
            EV_SHIFT_END: return "shift_end";
            EV_LATCH_BEG: return "latch_begin";
            EV_LATCH_END: return "latch_end";
            EV_START:     return "start_calc";
            EV_IDLE_BEG:  return "idle_begin";
            EV_IDLE_END:  return "idle_end";
            EV_OVR_SET:   return "overrun_set";
            default:      return "overrun_clear";
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic observe(int k, int v);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected, val %0d at cycle %0d, nothing required", kname(k), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.val != v) begin
                fails++;
                $display("FAIL %s: got val %0d at cycle %0d, required %s val %0d at cycle %0d",
                         kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    bit  pt = 1'b0, pl = 1'b0, pi = 1'b0, po = 1'b0;
    int  tx_len = 0, la_len = 0;
    ev_t me;

    always @(negedge clk) begin
        if (mon_on) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                me = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL %s: never seen, required val %0d at cycle %0d (now %0d)",
                         kname(me.kind), me.val, me.cyc, cyc);
            end
            if (zero_exp)
                check("reset_outputs",
                      int'({load_sreg, transmit_pixel, latching, start_calculating, idle, overrun, pixel}), 0);
            if (load_sreg)                 observe(EV_LOAD, int'(pixel));
            if (pt && !transmit_pixel)     observe(EV_SHIFT_END, tx_len);
            if (!pl && latching)           observe(EV_LATCH_BEG, 0);
            if (pl && !latching)           observe(EV_LATCH_END, la_len);
            if (start_calculating)         observe(EV_START, int'(pixel));
            if (!pi && idle)               observe(EV_IDLE_BEG, int'(pixel));
            if (pi && !idle)               observe(EV_IDLE_END, int'(pixel));
            if (!po && overrun)            observe(EV_OVR_SET, 0);
            if (po && !overrun)            observe(EV_OVR_CLR, 0);
            tx_len = transmit_pixel ? tx_len + 1 : 0;
            la_len = latching ? la_len + 1 : 0;
            pt = transmit_pixel;
            pl = latching;
            pi = idle;
            po = overrun;
            if (end_req) begin
                check("queue_drained", exp_q.size(), 0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    // ---------------- reference model + stimulus ----------------
    function automatic void add_ev(int c, int k, int v);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = fr_q.size();
        while (i > 0 && (fr_q[i-1].cyc > c || (fr_q[i-1].cyc == c && fr_q[i-1].kind > k))) i--;
        fr_q.insert(i, e);
    endfunction

    // mode: 0 done held before CALC, 1 done at CALC+doff, 2 done exactly at deadline,
    // 3 done doff cycles after the deadline. Enable drops mid-frame when pause is set
    // and returns eoff cycles after done is accepted.
    task automatic run_frame(int mode, int doff, bit pause, int eoff, bit clr_a, bit clr_b, bit do_rst);
        int s, c_calc, dn, e_cyc, s_next, last;
        bit late, waits;
        s      = cyc;
        c_calc = s + CALC_OFF;
        case (mode)
            0:       dn = c_calc;
            1:       dn = c_calc + doff;
            2:       dn = s + FP - 1;
            default: dn = s + FP + doff;
        endcase
        late  = (dn - s) >= FP;
        last  = s + 800;
        e_cyc = dn + 1 + eoff;
        fr_q.delete();

        for (int k = 0; k < NP; k++) begin
            if (!do_rst || s + k * P + 1 <= last)   add_ev(s + k * P + 1, EV_LOAD, k);
            if (!do_rst || s + (k + 1) * P <= last) add_ev(s + (k + 1) * P, EV_SHIFT_END, P - 2);
        end
        if (clr_a && ovr_m) add_ev(s + 301, EV_OVR_CLR, 0);
        if (clr_a) ovr_m = 1'b0;

        if (do_rst) begin
            add_ev(last + 1, EV_SHIFT_END, last + 1 - (s + 2 * P + 2));
            if (ovr_m) add_ev(last + 1, EV_OVR_CLR, 0);
            ovr_m  = 1'b0;
            s_next = last + 1;
            waits  = 1'b0;
        end else begin
            add_ev(s + NP * P, EV_LATCH_BEG, 0);
            add_ev(c_calc, EV_LATCH_END, LAT);
            add_ev(c_calc, EV_START, 0);
            if (clr_b && !late && ovr_m) begin
                add_ev(dn + 1, EV_OVR_CLR, 0);
                ovr_m = 1'b0;
            end
            if (late && !ovr_m) add_ev(dn + 1, EV_OVR_SET, 0);
            if (late) ovr_m = 1'b1;
            if (pause)     s_next = ((e_cyc > s + FP - 1) ? e_cyc : s + FP - 1) + 1;
            else if (late) s_next = dn + 1;
            else           s_next = s + FP;
            waits = (s_next > dn + 1);
            if (waits) begin
                add_ev(dn + 1, EV_IDLE_BEG, 0);
                add_ev(s_next, EV_IDLE_END, 0);
            end
        end
        foreach (fr_q[i]) exp_q.push_back(fr_q[i]);

        for (int c = s; c < s_next; c++) begin
            zero_exp         = after_rst && (c == s);
            rst_n            = !(do_rst && c == last);
            enable           = !(pause && c >= s + 500 && c < e_cyc);
            done_calculating = (c == dn) || (mode == 0 && c >= s + 1200 && c <= c_calc) ||
                               (c == s + 800) || (waits && c == dn + 2 && dn + 2 < s_next);
            overrun_clr      = (clr_a && c == s + 300) || (clr_b && c == dn);
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        after_rst = do_rst;
    endtask

    initial begin
        int m, d;
        rst_n            = 1'b0;
        enable           = 1'b1;
        done_calculating = 1'b0;
        overrun_clr      = 1'b0;
        @(posedge clk);
        #1;
        mon_on   = 1'b1;
        zero_exp = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        after_rst = 1'b1;

        run_frame(1, 42, 0, 0, 0, 0, 0);      // done at 1500, next frame at 2000
        run_frame(0, 0, 0, 0, 0, 0, 0);       // done already high when CALC starts
        run_frame(2, 0, 0, 0, 0, 0, 0);       // done at 1999: on time
        run_frame(3, 100, 0, 0, 0, 0, 0);     // done at 2100: overrun, READ at 2101
        run_frame(1, 42, 0, 0, 1, 0, 0);      // overrun_clr clears the sticky flag
        run_frame(1, 42, 1, 1499, 0, 0, 0);   // paused frame, enable back at 3000
        run_frame(3, 0, 0, 0, 0, 1, 0);       // set and clear together: set wins
        run_frame(3, 50, 1, 20, 0, 1, 0);     // late while already set, then paused

        for (int i = 0; i < 8; i++) begin
            m = $urandom_range(0, 3);
            d = (m == 1) ? $urandom_range(0, FP - 2 - CALC_OFF) : $urandom_range(0, 200);
            run_frame(m, d, ($urandom_range(0, 3) == 0), $urandom_range(0, 1000),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        run_frame(1, 42, 0, 0, 0, 0, 1);      // reset during pixel 2 shift
        run_frame(1, $urandom_range(0, FP - 2 - CALC_OFF), 0, 0, 0, 0, 0);
        run_frame(3, $urandom_range(0, 200), 0, 0, 0, 0, 0);
        end_req = 1'b1;
    end

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Parametrised frame sequencer for serial addressable-LED strips (24-bit GRB, one-wire). It replaces the fixed 64-pixel display controller. It walks pixel addresses, strobes the shift-register load, times each pixel's transmission, and inserts a strip latch gap. It then hands off to the frame-calculation engine over a start/done handshake and paces frames on a fixed period, measured start-to-start. New over the previous controller: synchronous reset, a latch gap, a run/pause enable, and sticky overrun detection when calculation misses the frame deadline.

## Interface
- NUM_PIXELS, 64: pixels per frame, ≥2.
- BITS_PER_PIXEL, 24: bits shifted per pixel.
- CYCLES_PER_BIT, 15: clock cycles per serial bit.
- LATCH_CYCLES, 600: line-low gap after the last pixel, ≥1 (50 µs at 12 MHz).
- FRAME_PERIOD_CYCLES, 12_000_000: frame start-to-start period in cycles.
- PIX_W, $clog2(NUM_PIXELS): width of `pixel` (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- enable  in  1  1 = run frames continuously; 0 = hold after the current frame's calculation completes.
- done_calculating  in  1  calc engine finished; sampled only in CALC.
- overrun_clr  in  1  clears `overrun`.
- start_calculating  out  1  one-cycle pulse, calc engine start.
- load_sreg  out  1  one-cycle strobe, load pixel data into the shift register.
- transmit_pixel  out  1  high while the serializer shifts the current pixel.
- latching  out  1  high during the latch gap.
- pixel  out  PIX_W  current pixel address (frame-buffer read address).
- idle  out  1  high in WAIT.
- overrun  out  1  sticky: calculation finished after the frame deadline.

## Operation
- States: READ, LOAD, SHIFT, LATCH, CALC, WAIT. Register all outputs or decode them from state only; no input-to-output combinational paths except as stated below.
- READ (1 cycle): `pixel` is valid to the buffer, giving one cycle of read latency → LOAD.
- LOAD (1 cycle): `load_sreg`=1 → SHIFT.
- SHIFT (BITS_PER_PIXEL×CYCLES_PER_BIT cycles): `transmit_pixel`=1; the shift counter runs 0..N-1.
  - On the last cycle, if `pixel`==NUM_PIXELS-1 → LATCH.
  - Otherwise `pixel`++ → READ.
- LATCH (LATCH_CYCLES cycles): `latching`=1 → CALC; `pixel` returns to 0.
- CALC: `start_calculating`=1 in the first CALC cycle only. Stay until `done_calculating`=1, which is also accepted in the first CALC cycle. Then:
  - timer < FRAME_PERIOD_CYCLES-1 → WAIT.
  - timer == FRAME_PERIOD_CYCLES-1 and enable → READ; the frame is on time.
  - timer == FRAME_PERIOD_CYCLES (saturated) → set `overrun`; go to READ if enable, else WAIT.
- WAIT: `idle`=1.
  - Exit to READ when enable=1 and timer ≥ FRAME_PERIOD_CYCLES-1.
  - If enable=0, stay in WAIT indefinitely. When enable rises with the timer already expired, go to READ on the next cycle.
- enable is sampled only at CALC/WAIT exits. Dropping enable mid-frame does not truncate the frame.
- Frame timer, width $clog2(FRAME_PERIOD_CYCLES+1):
  - Cleared to 0 on the cycle READ is entered for pixel 0.
  - Increments every cycle and saturates at FRAME_PERIOD_CYCLES.
- `overrun`: set wins over a simultaneous `overrun_clr`. It is cleared only by `overrun_clr` or reset.
- `done_calculating` outside CALC is ignored.

## Timing
- Reset (rst_n=0 at a posedge): the next state is READ with pixel=0 and timer=0.
  - Outputs during reset: load_sreg, transmit_pixel, latching, start_calculating, idle, overrun are all 0; pixel=0.
  - Reset mid-frame or mid-calc aborts immediately; no start/done is owed.
- After reset release, the first frame starts at once (READ at the first cycle).
- Per-pixel time: 2 + BITS_PER_PIXEL×CYCLES_PER_BIT cycles (362 at default).
- With frame start at cycle 0:
  - Pixel k: READ at k·P, LOAD at k·P+1, SHIFT from k·P+2 through (k+1)·P-1.
  - LATCH occupies cycles NUM_PIXELS·P through NUM_PIXELS·P+LATCH_CYCLES-1.
  - CALC starts at NUM_PIXELS·P+LATCH_CYCLES.
- On-time frames start exactly FRAME_PERIOD_CYCLES apart.
- An overrun frame starts the cycle after `done_calculating` is accepted.
- If FRAME_PERIOD_CYCLES is shorter than the transmit time, every frame overruns; no other failure.

## Test plan
Parameters for all scenarios: NUM_PIXELS=4, BITS_PER_PIXEL=24, CYCLES_PER_BIT=15, LATCH_CYCLES=10, FRAME_PERIOD_CYCLES=2000, so P=362.
1. Release reset at cycle 0, enable=1, done at cycle 1500 → load_sreg at cycles 1, 363, 725, 1087; pixel 0,1,2,3; transmit_pixel high 1447-1088+1=360 cycles for pixel 3; latching at 1448-1457; start_calculating at 1458 only; idle from 1501; next READ at 2000.
2. Done held high before CALC → start_calculating and done coincide at 1458; WAIT from 1459; next frame at 2000; overrun=0.
3. Done at cycle 1999 → READ at 2000, overrun=0. Done at cycle 2100 → READ at 2101, overrun=1. Hold overrun_clr=1 for one cycle → overrun=0.
4. Drop enable at cycle 500, done at 1500 → frame completes normally; WAIT held past 2000. Raise enable at 3000 → READ at 3001, pixel=0.
5. Pull rst_n low at cycle 800 (mid pixel 2 SHIFT) → next cycle all outputs are 0 and pixel=0. Release → a full frame restarts, with load_sreg one cycle after the first READ.
6. Pulse done_calculating during SHIFT and during WAIT → no effect. overrun_clr and an overrun set in the same cycle → overrun=1.
